im_mem_stage: RTL and testbench
===============================

Name: im_mem_stage

Overview:
- Memory-access (IM) stage logic, directly upstream of the IM/IW pipeline register.
- Takes the ALU result and store operand from IX/IM and runs loads and stores on the data bus with a req/ack handshake.
- Aligns and sign-extends load data and produces the O value latched by IM/IW.
- Freezes the pipeline while an access is outstanding, and flags misaligned or timed-out accesses so writeback can be suppressed.

Parameters:
TIMEOUT, 16, number of ACCESS cycles without dbus_ack before the access is aborted (valid range 2..255).

Ports:
clk  in  1  core clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
valid_in  in  1  IX/IM holds a live instruction.
mem_read_in  in  1  instruction is a load.
mem_write_in  in  1  instruction is a store (mem_read_in and mem_write_in are never both set).
access_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
load_unsigned_in  in  1  1 = zero-extend loads, 0 = sign-extend.
addr_in  in  32  ALU result; the effective address for memory ops.
store_data_in  in  32  rt operand for stores.
dbus_req  out  1  bus request.
dbus_we  out  1  1 = write.
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
dbus_be  out  4  byte enables.
dbus_wdata  out  32  lane-replicated store data.
dbus_rdata  in  32  read data, valid with dbus_ack.
dbus_ack  in  1  access complete.
O_out  out  32  value for IM/IW O_in.
stall_out  out  1  freeze request to IM/IW stall_in and upstream stages.
wb_kill  out  1  forces write_to_reg low in IM/IW.
misalign_err  out  1  one-cycle pulse on a misaligned access.
bus_timeout  out  1  one-cycle pulse on an aborted access.

Behaviour:
- memop = valid_in & (mem_read_in | mem_write_in).
- misaligned = half with addr_in[0]=1, or word with addr_in[1:0]!=0.
- States: IDLE, ACCESS, DONE.
- IDLE, no memop: O_out = addr_in combinationally; stall_out = 0; wb_kill = 0; dbus_req = 0.
- IDLE, memop & misaligned: no bus access; stays in IDLE; misalign_err = 1 and wb_kill = 1 (combinational, same cycle); O_out = 0; stall_out = 0.
- IDLE, memop & aligned:
  - stall_out = 1 combinationally.
  - At posedge, capture dbus_addr, dbus_we, dbus_be, dbus_wdata, the byte offset, size and unsigned flag; clear the timeout counter; go to ACCESS.
- ACCESS:
  - dbus_req = 1; all bus outputs held stable from the captured registers; stall_out = 1.
  - On posedge with dbus_ack = 1: for a read, register the extracted load data; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, go to DONE with the timeout flag set, and drop dbus_req.
- DONE:
  - stall_out = 0.
  - O_out = registered load data for reads, or addr_in for stores.
  - If the timeout flag is set: O_out = 0, wb_kill = 1, bus_timeout = 1.
  - Unconditional transition to IDLE. DONE never retriggers, because the same instruction is still present in this cycle.
- Latency: minimum 2 stalled cycles (IDLE detect + one ACCESS cycle with immediate ack); each extra wait cycle adds 1; worst case TIMEOUT+1.
- Load extraction (little-endian):
  - byte = rdata[8*off+7 : 8*off].
  - half = rdata[31:16] if off[1] else rdata[15:0].
  - Extended to 32 bits per load_unsigned.
- Store formatting:
  - byte: wdata = {4{b}}, be = 0001<<off.
  - half: wdata = {2{h}}, be = 0011 or 1100.
  - word: wdata = data, be = 1111.
  - Reads drive be per size the same way; dbus_wdata is don't-care on reads.
- dbus_ack outside ACCESS is ignored.
- Reset: async to IDLE; counter, flags and load-data register cleared; dbus_req, stall_out, wb_kill and both error pulses go to 0 immediately. An access aborted by reset is not reissued.

Test Plan:
1. Load word, addr 0x100, rdata 0xDEADBEEF, ack in first ACCESS cycle -> dbus_addr 0x100, be 1111, stall_out high exactly 2 cycles, O_out 0xDEADBEEF in DONE.
2. Signed load byte, addr 0x203, rdata 0x80FF_0000; then the unsigned variant -> be 1000, O_out 0xFFFFFF80 (signed), 0x00000080 (unsigned).
3. Store half, addr 0x402, data 0x1234ABCD, ack after 3 wait cycles -> dbus_we 1, be 1100, wdata 0xABCDABCD held stable 4 ACCESS cycles, stall_out high 5 cycles.
4. Load word, addr 0x101 -> misalign_err and wb_kill pulse 1 cycle, dbus_req never rises, stall_out 0, O_out 0.
5. TIMEOUT=16, no ack -> dbus_req high 16 cycles then low; DONE has bus_timeout = wb_kill = 1 and O_out 0; any later ack is ignored.
6. rst_n low in the 2nd ACCESS cycle -> dbus_req and stall_out drop before the next clk edge; after release, a non-memop gives O_out = addr_in with stall 0.

Source files
------------

// File: rtl/im_mem_stage.sv
// im_mem_stage: memory-access stage ahead of IM/IW. Runs loads/stores on a req/ack data bus, aligns load data, and produces O.
// Ports: pipeline inputs (valid/mem_read/mem_write/size/unsigned/addr/store data), dbus_* request and response, O_out and stall/kill/error flags.
// Latency: at least 2 stalled cycles per memop (detect + one ACCESS cycle), TIMEOUT+1 worst case. stall_out freezes upstream while a memop is in flight.
module im_mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  access_size_in,
   input  logic        load_unsigned_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic [31:0] O_out,
   output logic        stall_out,
   output logic        wb_kill,
   output logic        misalign_err,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;

   // Captured access
   logic [31:0] addr_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [7:0]  cnt_q;
   logic        to_q;
   logic [31:0] ld_q;

   logic        memop;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] rd_shift;
   logic [31:0] ld_ext;

   assign memop = valid_in & (mem_read_in | mem_write_in);

   always_comb begin
      misaligned = 1'b0;
      case (access_size_in)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_in[0];
         default: misaligned = (addr_in[1:0] != 2'b00);
      endcase
   end

   // Byte enables and lane-replicated store data for the incoming instruction
   always_comb begin
      be_new    = 4'b1111;
      wdata_new = store_data_in;
      case (access_size_in)
         2'b00: begin
            be_new    = 4'b0001 << addr_in[1:0];
            wdata_new = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{store_data_in[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = store_data_in;
         end
      endcase
   end

   // Little-endian load extraction using the captured offset/size/sign mode
   assign rd_shift = dbus_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_ext = dbus_rdata;
      case (size_q)
         2'b00: ld_ext = uns_q ? {24'h0, rd_shift[7:0]}
                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01: begin
            if (off_q[1])
               ld_ext = uns_q ? {16'h0, dbus_rdata[31:16]}
                              : {{16{dbus_rdata[31]}}, dbus_rdata[31:16]};
            else
               ld_ext = uns_q ? {16'h0, dbus_rdata[15:0]}
                              : {{16{dbus_rdata[15]}}, dbus_rdata[15:0]};
         end
         default: ld_ext = dbus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 32'h0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         off_q   <= 2'b00;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         cnt_q   <= 8'h0;
         to_q    <= 1'b0;
         ld_q    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (memop && !misaligned) begin
                  addr_q  <= {addr_in[31:2], 2'b00};
                  we_q    <= mem_write_in;
                  be_q    <= be_new;
                  wdata_q <= wdata_new;
                  off_q   <= addr_in[1:0];
                  size_q  <= access_size_in;
                  uns_q   <= load_unsigned_in;
                  cnt_q   <= 8'h0;
                  to_q    <= 1'b0;
               end
            end
            ACCESS: begin
               if (dbus_ack) begin
                  if (!we_q)
                     ld_q <= ld_ext;
               end else if (cnt_q == CNT_LAST) begin
                  to_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (memop && !misaligned) state_nxt = ACCESS;
         ACCESS:  if (dbus_ack || cnt_q == CNT_LAST) state_nxt = DONE;
         // The instruction that just finished is still on the inputs here,
         // so DONE always returns to IDLE without looking at memop.
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   logic stall_i, kill_i, mis_i, to_pulse_i;

   always_comb begin
      O_out      = addr_in;
      stall_i    = 1'b0;
      kill_i     = 1'b0;
      mis_i      = 1'b0;
      to_pulse_i = 1'b0;
      dbus_req   = 1'b0;
      case (state)
         IDLE: begin
            if (memop && misaligned) begin
               mis_i  = 1'b1;
               kill_i = 1'b1;
               O_out  = 32'h0;
            end else if (memop) begin
               stall_i = 1'b1;
            end
         end
         ACCESS: begin
            dbus_req = 1'b1;
            stall_i  = 1'b1;
         end
         DONE: begin
            if (to_q) begin
               O_out      = 32'h0;
               kill_i     = 1'b1;
               to_pulse_i = 1'b1;
            end else if (!we_q) begin
               O_out = ld_q;
            end
         end
         default: ;
      endcase
   end

   // Bus side is always driven from the captured registers so it stays stable for the whole access.
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_be    = be_q;
   assign dbus_wdata = wdata_q;

   // Flags are forced low while reset is asserted, even if a memop is still on the inputs.
   assign stall_out    = stall_i & rst_n;
   assign wb_kill      = kill_i & rst_n;
   assign misalign_err = mis_i & rst_n;
   assign bus_timeout  = to_pulse_i & rst_n;

endmodule

// File: tb/tb_im_mem_stage.sv
module tb_im_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        mem_read_in = 1'b0;
   logic        mem_write_in = 1'b0;
   logic [1:0]  access_size_in = 2'b00;
   logic        load_unsigned_in = 1'b0;
   logic [31:0] addr_in = 32'h0;
   logic [31:0] store_data_in = 32'h0;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata = 32'h0;
   logic        dbus_ack = 1'b0;
   logic [31:0] O_out;
   logic        stall_out;
   logic        wb_kill;
   logic        misalign_err;
   logic        bus_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Per-operation observations collected by run_op
   int          r_stall;
   int          r_req;
   logic [31:0] r_o;
   logic        r_kill;
   logic        r_tout;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic        r_stable;

   im_mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .access_size_in(access_size_in), .load_unsigned_in(load_unsigned_in),
      .addr_in(addr_in), .store_data_in(store_data_in),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .O_out(O_out), .stall_out(stall_out), .wb_kill(wb_kill),
      .misalign_err(misalign_err), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
      valid_in         = 1'b1;
      mem_read_in      = rd;
      mem_write_in     = wr;
      access_size_in   = sz;
      load_unsigned_in = uns;
      addr_in          = a;
      store_data_in    = d;
   endtask

   task automatic clear_op();
      valid_in     = 1'b0;
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
   endtask

   // Called at a negedge just after set_op. Acks the access in its (waits+1)-th
   // ACCESS cycle, returns at the negedge of the DONE cycle with results sampled.
   task automatic run_op(input int waits, input logic [31:0] rdata, input string tag);
      int  seen;
      bit  done;
      seen     = 0;
      done     = 0;
      r_stall  = 0;
      r_req    = 0;
      r_stable = 1'b1;
      #1;
      for (int i = 0; i < 60 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (stall_out) begin
            r_stall++;
         end else if (r_stall > 0) begin
            r_o    = O_out;
            r_kill = wb_kill;
            r_tout = bus_timeout;
            done   = 1;
         end
         if (dbus_req) begin
            if (r_req == 0) begin
               r_we = dbus_we; r_addr = dbus_addr; r_be = dbus_be; r_wdata = dbus_wdata;
            end else if (dbus_we !== r_we || dbus_addr !== r_addr ||
                         dbus_be !== r_be || dbus_wdata !== r_wdata) begin
               r_stable = 1'b0;
            end
            r_req++;
            dbus_ack   = (seen == waits);
            dbus_rdata = rdata;
            seen++;
         end else begin
            dbus_ack = 1'b0;
         end
      end
      dbus_ack = 1'b0;
      if (!done) check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
      clear_op();
   endtask

   initial begin
      logic req_seen;
      // Reset state
      addr_in = 32'h0000_0055;
      #2;
      check_val("rst_req", {31'h0, dbus_req}, 32'd0);
      check_val("rst_stall", {31'h0, stall_out}, 32'd0);
      check_val("rst_kill", {31'h0, wb_kill}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle_o_pass", O_out, 32'h0000_0055);

      // 1: load word, immediate ack
      set_op(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
      run_op(0, 32'hDEAD_BEEF, "lw");
      check_val("lw_addr", r_addr, 32'h0000_0100);
      check_val("lw_be", {28'h0, r_be}, 32'hF);
      check_val("lw_stall", r_stall, 32'd2);
      check_val("lw_req", r_req, 32'd1);
      check_val("lw_o", r_o, 32'hDEAD_BEEF);
      check_val("lw_kill", {31'h0, r_kill}, 32'd0);
      @(negedge clk);

      // 2: signed and unsigned byte load at offset 3
      set_op(1, 0, 2'b00, 0, 32'h0000_0203, 32'h0);
      run_op(0, 32'h80FF_0000, "lbs");
      check_val("lb_be", {28'h0, r_be}, 32'h8);
      check_val("lb_addr", r_addr, 32'h0000_0200);
      check_val("lbs_o", r_o, 32'hFFFF_FF80);
      @(negedge clk);
      set_op(1, 0, 2'b00, 1, 32'h0000_0203, 32'h0);
      run_op(1, 32'h80FF_0000, "lbu");
      check_val("lbu_o", r_o, 32'h0000_0080);
      check_val("lbu_stall", r_stall, 32'd3);
      @(negedge clk);

      // Signed half load, upper half
      set_op(1, 0, 2'b01, 0, 32'h0000_0506, 32'h0);
      run_op(0, 32'h8001_7FFF, "lh");
      check_val("lh_be", {28'h0, r_be}, 32'hC);
      check_val("lh_o", r_o, 32'hFFFF_8001);
      @(negedge clk);

      // 3: store half, 3 wait cycles
      set_op(0, 1, 2'b01, 0, 32'h0000_0402, 32'h1234_ABCD);
      run_op(3, 32'h0, "sh");
      check_val("sh_we", {31'h0, r_we}, 32'd1);
      check_val("sh_be", {28'h0, r_be}, 32'hC);
      check_val("sh_wdata", r_wdata, 32'hABCD_ABCD);
      check_val("sh_stable", {31'h0, r_stable}, 32'd1);
      check_val("sh_req", r_req, 32'd4);
      check_val("sh_stall", r_stall, 32'd5);
      check_val("sh_o", r_o, 32'h0000_0402);
      @(negedge clk);

      // Store byte at offset 1
      set_op(0, 1, 2'b00, 0, 32'h0000_0601, 32'h0000_00AB);
      run_op(0, 32'h0, "sb");
      check_val("sb_be", {28'h0, r_be}, 32'h2);
      check_val("sb_wdata", r_wdata, 32'hABAB_ABAB);
      @(negedge clk);

      // 4: misaligned word load
      set_op(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0);
      #1;
      check_val("mis_err", {31'h0, misalign_err}, 32'd1);
      check_val("mis_kill", {31'h0, wb_kill}, 32'd1);
      check_val("mis_stall", {31'h0, stall_out}, 32'd0);
      check_val("mis_o", O_out, 32'h0);
      req_seen = dbus_req;
      @(negedge clk);
      req_seen = req_seen | dbus_req;
      clear_op();
      #1;
      check_val("mis_pulse_end", {31'h0, misalign_err}, 32'd0);
      @(negedge clk);
      req_seen = req_seen | dbus_req;
      check_val("mis_no_req", {31'h0, req_seen}, 32'd0);

      // 5: timeout, no ack
      set_op(1, 0, 2'b10, 0, 32'h0000_0700, 32'h0);
      run_op(1000, 32'h0, "to");
      check_val("to_req", r_req, 32'd16);
      check_val("to_stall", r_stall, 32'd17);
      check_val("to_flag", {31'h0, r_tout}, 32'd1);
      check_val("to_kill", {31'h0, r_kill}, 32'd1);
      check_val("to_o", r_o, 32'h0);
      addr_in  = 32'h0000_0999;
      dbus_ack = 1'b1;
      @(negedge clk);
      check_val("to_pulse_end", {31'h0, bus_timeout}, 32'd0);
      @(negedge clk);
      check_val("late_ack_req", {31'h0, dbus_req}, 32'd0);
      check_val("late_ack_stall", {31'h0, stall_out}, 32'd0);
      check_val("late_ack_o", O_out, 32'h0000_0999);
      dbus_ack = 1'b0;

      // 6: reset in the 2nd ACCESS cycle
      set_op(1, 0, 2'b10, 0, 32'h0000_0300, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #2;
      check_val("pre_rst_req", {31'h0, dbus_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_req", {31'h0, dbus_req}, 32'd0);
      check_val("rst_mid_stall", {31'h0, stall_out}, 32'd0);
      @(negedge clk);
      clear_op();
      addr_in = 32'h0000_0777;
      rst_n   = 1'b1;
      @(negedge clk);
      check_val("post_rst_o", O_out, 32'h0000_0777);
      check_val("post_rst_stall", {31'h0, stall_out}, 32'd0);
      req_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         req_seen = req_seen | dbus_req;
      end
      check_val("post_rst_no_req", {31'h0, req_seen}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
